// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the ALU issue controller and its register file.
//   - word, flag, opcode and register-address widths
//   - bit positions of the fields in the 18-bit instruction word
//   - opcode constants and a legality helper
//   - FSM state type of the issue controller
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int WORD_W  = 19;
    localparam int FLAG_W  = 8;
    localparam int OPC_W   = 6;
    localparam int REG_AW  = 3;
    localparam int REG_NUM = 8;
    localparam int IMM_W   = 3;
    localparam int INSTR_W = 18;

    // Instruction word layout: opcode | rd | rs1 | rs2 | imm
    localparam int OPC_MSB = 17;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 2;
    localparam int IMM_LSB = 0;

    // ALU flag bit reporting a divide by zero
    localparam int FLAG_DIV0 = 0;

    // Legal opcodes form one contiguous run plus one isolated code
    localparam logic [OPC_W-1:0] OP_ADD       = 6'b000001;
    localparam logic [OPC_W-1:0] OP_RUN_LAST  = 6'b001001;
    localparam logic [OPC_W-1:0] OP_ISOLATED  = 6'b001011;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    function automatic logic is_legal_opcode(input logic [OPC_W-1:0] op);
        return ((op >= OP_ADD) && (op <= OP_RUN_LAST)) || (op == OP_ISOLATED);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
// 8 x 19-bit register file with two asynchronous read ports and a single
// write port shared by a host writer and the ALU writeback. When both write
// the same register on the same edge, the writeback value is kept.
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   host_we/host_waddr/host_wdata host write request
//   wb_we/wb_waddr/wb_wdata       ALU writeback request (higher priority)
//   raddr_a/rdata_a               read port A (combinational)
//   raddr_b/rdata_b               read port B (combinational)
// ---------------------------------------------------------------------------
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              host_we,
    input  logic [REG_AW-1:0] host_waddr,
    input  logic [WORD_W-1:0] host_wdata,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_waddr,
    input  logic [WORD_W-1:0] wb_wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [WORD_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [WORD_W-1:0] rdata_b
);

    logic [WORD_W-1:0] mem_q [REG_NUM];
    logic [WORD_W-1:0] mem_d [REG_NUM];

    // The writeback is applied after the host write so it wins a collision
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (host_we) begin
            mem_d[host_waddr] = host_wdata;
        end
        if (wb_we) begin
            mem_d[wb_waddr] = wb_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Accepts one instruction at a time, reads its operands from a local register
// file, issues a single-cycle request to an external ALU, captures the ALU
// result in the following cycle, writes it back (unless the ALU reports a
// divide by zero) and presents it on a ready/valid result channel.
// Illegal opcodes bypass the ALU and return an error response.
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   instr_valid/instr_ready/instr      instruction channel
//   rf_we/rf_waddr/rf_wdata            host register-file write
//   aluen/opcode/r2/r3/imm             request to the ALU
//   r1/FLAG                            ALU result, valid the cycle after aluen
//   res_valid/res_ready/res_data/
//   res_flag/res_err                   result channel
//   sticky_flag                        OR of all captured flags; present only
//                                      when ALU_ISSUE_STICKY_FLAG_EN is defined
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               rf_we,
    input  logic [REG_AW-1:0]  rf_waddr,
    input  logic [WORD_W-1:0]  rf_wdata,
    output logic               aluen,
    output logic [OPC_W-1:0]   opcode,
    output logic [WORD_W-1:0]  r2,
    output logic [WORD_W-1:0]  r3,
    output logic [IMM_W-1:0]   imm,
    input  logic [WORD_W-1:0]  r1,
    input  logic [FLAG_W-1:0]  FLAG,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WORD_W-1:0]  res_data,
    output logic [FLAG_W-1:0]  res_flag,
    output logic               res_err
`ifdef ALU_ISSUE_STICKY_FLAG_EN
    ,
    output logic [FLAG_W-1:0]  sticky_flag
`endif
);

    state_t            state_q, state_d;
    logic              ready_en_q, ready_en_d;
    logic [OPC_W-1:0]  opcode_q, opcode_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [REG_AW-1:0] rs1_q, rs1_d;
    logic [REG_AW-1:0] rs2_q, rs2_d;
    logic [IMM_W-1:0]  imm_q, imm_d;
    logic [WORD_W-1:0] res_data_q, res_data_d;
    logic [FLAG_W-1:0] res_flag_q, res_flag_d;
    logic              res_err_q, res_err_d;
`ifdef ALU_ISSUE_STICKY_FLAG_EN
    logic [FLAG_W-1:0] sticky_q, sticky_d;
`endif

    logic              handshake;
    logic              wb_we;
    logic [WORD_W-1:0] rdata_a;
    logic [WORD_W-1:0] rdata_b;

    alu_regfile u_rf (
        .clk        (clk),
        .reset      (reset),
        .host_we    (rf_we),
        .host_waddr (rf_waddr),
        .host_wdata (rf_wdata),
        .wb_we      (wb_we),
        .wb_waddr   (rd_q),
        .wb_wdata   (r1),
        .raddr_a    (rs1_q),
        .rdata_a    (rdata_a),
        .raddr_b    (rs2_q),
        .rdata_b    (rdata_b)
    );

    // ready_en_q keeps instr_ready low while reset is held even though the
    // state register already sits in IDLE; it rises on the first edge after
    // reset is released.
    assign instr_ready = ready_en_q && (state_q == ST_IDLE);
    assign handshake   = instr_valid && instr_ready;

    // The ALU request is only driven during ISSUE. Operands come straight
    // from the register file so a host write on the ISSUE edge lands after
    // the ALU has already sampled them.
    assign aluen  = (state_q == ST_ISSUE);
    assign opcode = aluen ? opcode_q : '0;
    assign r2     = aluen ? rdata_a  : '0;
    assign r3     = aluen ? rdata_b  : '0;
    assign imm    = aluen ? imm_q    : '0;

    assign res_valid = (state_q == ST_RESP);
    assign res_data  = res_data_q;
    assign res_flag  = res_flag_q;
    assign res_err   = res_err_q;

    // Next-state and datapath update. The ALU clears r1 one cycle after it
    // presents it, so the capture and writeback both happen on the single
    // edge that closes CAPTURE.
    always_comb begin
        state_d    = state_q;
        ready_en_d = 1'b1;
        opcode_d   = opcode_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        imm_d      = imm_q;
        res_data_d = res_data_q;
        res_flag_d = res_flag_q;
        res_err_d  = res_err_q;
        wb_we      = 1'b0;
`ifdef ALU_ISSUE_STICKY_FLAG_EN
        sticky_d   = sticky_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    if (is_legal_opcode(instr[OPC_MSB:OPC_LSB])) begin
                        opcode_d = instr[OPC_MSB:OPC_LSB];
                        rd_d     = instr[RD_MSB:RD_LSB];
                        rs1_d    = instr[RS1_MSB:RS1_LSB];
                        rs2_d    = instr[RS2_MSB:RS2_LSB];
                        imm_d    = instr[IMM_MSB:IMM_LSB];
                        state_d  = ST_ISSUE;
                    end else begin
                        res_data_d = '0;
                        res_flag_d = '0;
                        res_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                res_data_d = r1;
                res_flag_d = FLAG;
                res_err_d  = FLAG[FLAG_DIV0];
                wb_we      = !FLAG[FLAG_DIV0];
`ifdef ALU_ISSUE_STICKY_FLAG_EN
                sticky_d   = sticky_q | FLAG;
`endif
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ready_en_q <= 1'b0;
            opcode_q   <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            res_data_q <= '0;
            res_flag_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= ready_en_d;
            opcode_q   <= opcode_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            imm_q      <= imm_d;
            res_data_q <= res_data_d;
            res_flag_q <= res_flag_d;
            res_err_q  <= res_err_d;
        end
    end

`ifdef ALU_ISSUE_STICKY_FLAG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flag = sticky_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Self-checking bench for alu_issue_ctrl. A behavioural ALU answers the
// controller's requests; a transaction-level reference (register array plus
// the ALU function) predicts every response, operand and register value.
// Build with ALU_ISSUE_STICKY_FLAG_EN defined to connect sticky_flag.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [17:0] instr;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [18:0] rf_wdata;
    logic        aluen;
    logic [5:0]  opcode;
    logic [18:0] r2;
    logic [18:0] r3;
    logic [2:0]  imm;
    logic [18:0] r1;
    logic [7:0]  FLAG;
    logic        res_valid;
    logic        res_ready;
    logic [18:0] res_data;
    logic [7:0]  res_flag;
    logic        res_err;
`ifdef ALU_ISSUE_STICKY_FLAG_EN
    logic [7:0]  sticky_flag;
`endif

    int          cmp_count = 0;
    int          mismatch_count = 0;
    int          aluen_count = 0;
    logic [18:0] ref_rf [8];
    time         last_hs = 0;
    time         prev_hs = 0;
    logic [18:0] obs_data;
    logic [7:0]  obs_flag;
    logic        obs_err;

    alu_issue_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .aluen       (aluen),
        .opcode      (opcode),
        .r2          (r2),
        .r3          (r3),
        .imm         (imm),
        .r1          (r1),
        .FLAG        (FLAG),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_flag    (res_flag),
        .res_err     (res_err)
`ifdef ALU_ISSUE_STICKY_FLAG_EN
        ,
        .sticky_flag (sticky_flag)
`endif
    );

    always #5 clk = ~clk;

    // ALU behaviour: flag[7] negative, flag[6] carry/borrow, flag[1] zero,
    // flag[0] divide by zero. Returns {flag, result}.
    function automatic logic [26:0] aluModel(input logic [5:0] op, input logic [18:0] a,
                                             input logic [18:0] b, input logic [2:0] im);
        logic [19:0] wide;
        logic [18:0] res;
        logic [7:0]  fl;
        wide = '0;
        fl   = '0;
        case (op)
            6'd1:  wide = {1'b0, a} + {1'b0, b};
            6'd2:  wide = {1'b0, a} - {1'b0, b};
            6'd3:  wide = {1'b0, a * b};
            6'd4:  begin
                if (b == '0) fl[0] = 1'b1;
                else         wide = {1'b0, a / b};
            end
            6'd5:  wide = {1'b0, a & b};
            6'd6:  wide = {1'b0, a | b};
            6'd7:  wide = {1'b0, a ^ b};
            6'd8:  wide = {1'b0, a << im};
            6'd9:  wide = {1'b0, a >> im};
            6'd11: wide = {1'b0, a} + {17'd0, im};
            default: wide = '0;
        endcase
        res   = wide[18:0];
        fl[7] = res[18];
        fl[6] = wide[19];
        fl[1] = (res == '0);
        return {fl, res};
    endfunction

    // External ALU: samples the request on the aluen edge, presents the
    // result for exactly one cycle, then clears it.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            r1   <= '0;
            FLAG <= '0;
        end else if (aluen === 1'b1) begin
            {FLAG, r1} <= aluModel(opcode, r2, r3, imm);
        end else begin
            r1   <= '0;
            FLAG <= '0;
        end
    end

    always @(posedge clk) begin
        if (aluen === 1'b1) aluen_count <= aluen_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        cmp_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic hostWrite(input logic [2:0] addr, input logic [18:0] data);
        @(negedge clk);
        rf_we    = 1'b1;
        rf_waddr = addr;
        rf_wdata = data;
        @(posedge clk);
        #1;
        rf_we = 1'b0;
        ref_rf[addr] = data;
    endtask

    // One full instruction: handshake, issue, capture, response. Optional
    // host writes are driven onto the ISSUE edge (hi_*) and the CAPTURE
    // edge (hc_*). hold = cycles res_ready stays low once in RESP.
    task automatic applyStimulus(input logic [17:0] ins, input int hold,
                                 input logic hi_en, input logic [2:0] hi_addr, input logic [18:0] hi_data,
                                 input logic hc_en, input logic [2:0] hc_addr, input logic [18:0] hc_data);
        logic [5:0]  op;
        logic [2:0]  rd, rs1, rs2, im;
        logic        legal;
        logic [26:0] mres;
        logic [18:0] e_data;
        logic [7:0]  e_flag;
        logic        e_err;
        int          guard;
        int          cnt0;
        op    = ins[17:12];
        rd    = ins[11:9];
        rs1   = ins[8:6];
        rs2   = ins[5:3];
        im    = ins[2:0];
        legal = ((op >= 6'd1) && (op <= 6'd9)) || (op == 6'd11);
        mres  = aluModel(op, ref_rf[rs1], ref_rf[rs2], im);
        e_data = legal ? mres[18:0]  : 19'd0;
        e_flag = legal ? mres[26:19] : 8'd0;
        e_err  = !legal || mres[19];

        guard = 0;
        @(negedge clk);
        while (instr_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (instr_ready !== 1'b1) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            return;
        end
        instr       = ins;
        instr_valid = 1'b1;
        cnt0        = aluen_count;
        @(posedge clk);
        prev_hs = last_hs;
        last_hs = $time;
        #1;
        instr_valid = 1'b0;
        instr       = 18'($urandom);
        @(negedge clk);

        if (legal) begin
            checkOutput("issue_aluen",  32'(aluen),       32'd1);
            checkOutput("issue_opcode", 32'(opcode),      32'(op));
            checkOutput("issue_r2",     32'(r2),          32'(ref_rf[rs1]));
            checkOutput("issue_r3",     32'(r3),          32'(ref_rf[rs2]));
            checkOutput("issue_imm",    32'(imm),         32'(im));
            checkOutput("issue_ready",  32'(instr_ready), 32'd0);
            checkOutput("issue_valid",  32'(res_valid),   32'd0);
            if (hi_en) begin
                rf_we    = 1'b1;
                rf_waddr = hi_addr;
                rf_wdata = hi_data;
            end
            @(negedge clk);
            rf_we = 1'b0;
            checkOutput("cap_aluen", 32'(aluen),     32'd0);
            checkOutput("cap_valid", 32'(res_valid), 32'd0);
            if (hc_en) begin
                rf_we    = 1'b1;
                rf_waddr = hc_addr;
                rf_wdata = hc_data;
            end
            @(negedge clk);
            rf_we = 1'b0;
        end

        obs_data = res_data;
        obs_flag = res_flag;
        obs_err  = res_err;
        checkOutput("resp_valid",  32'(res_valid),   32'd1);
        checkOutput("resp_data",   32'(res_data),    32'(e_data));
        checkOutput("resp_flag",   32'(res_flag),    32'(e_flag));
        checkOutput("resp_err",    32'(res_err),     32'(e_err));
        checkOutput("resp_aluen",  32'(aluen),       32'd0);
        checkOutput("resp_r2",     32'(r2),          32'd0);
        checkOutput("resp_ready",  32'(instr_ready), 32'd0);
        checkOutput("aluen_cycles", 32'(aluen_count - cnt0), legal ? 32'd1 : 32'd0);

        if (hold > 0) begin
            res_ready = 1'b0;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                checkOutput("hold_valid", 32'(res_valid),   32'd1);
                checkOutput("hold_data",  32'(res_data),    32'(e_data));
                checkOutput("hold_flag",  32'(res_flag),    32'(e_flag));
                checkOutput("hold_err",   32'(res_err),     32'(e_err));
                checkOutput("hold_ready", 32'(instr_ready), 32'd0);
            end
            res_ready = 1'b1;
        end
        @(posedge clk);
        #1;

        if (legal && hi_en) ref_rf[hi_addr] = hi_data;
        if (legal && hc_en) ref_rf[hc_addr] = hc_data;
        if (legal && !mres[19]) ref_rf[rd] = mres[18:0];
    endtask

    // Reads a register by OR-ing it with itself into itself
    task automatic readReg(input logic [2:0] idx);
        applyStimulus({6'd6, idx, idx, idx, 3'd0}, 0, 1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
    endtask

    initial begin
        logic [5:0]  rop;
        logic [17:0] rins;
        int          sel;
        int          guard;

        reset       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        res_ready   = 1'b1;
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_instr_ready", 32'(instr_ready), 32'd0);
        checkOutput("rst_aluen",       32'(aluen),       32'd0);
        checkOutput("rst_opcode",      32'(opcode),      32'd0);
        checkOutput("rst_r2",          32'(r2),          32'd0);
        checkOutput("rst_r3",          32'(r3),          32'd0);
        checkOutput("rst_imm",         32'(imm),         32'd0);
        checkOutput("rst_res_valid",   32'(res_valid),   32'd0);
        checkOutput("rst_res_data",    32'(res_data),    32'd0);
        checkOutput("rst_res_flag",    32'(res_flag),    32'd0);
        checkOutput("rst_res_err",     32'(res_err),     32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rdy_before_edge", 32'(instr_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rdy_after_edge", 32'(instr_ready), 32'd1);

        // Directed: ADD, SUB, DIV by zero, illegal opcode
        hostWrite(3'd1, 19'd5);
        hostWrite(3'd2, 19'd7);
        applyStimulus({6'b000001, 3'd3, 3'd1, 3'd2, 3'd0}, 0, 1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
        checkOutput("add_data", 32'(obs_data), 32'd12);
        checkOutput("add_flag", 32'(obs_flag), 32'd0);
        readReg(3'd3);

        applyStimulus({6'b000010, 3'd4, 3'd1, 3'd2, 3'd0}, 0, 1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
        checkOutput("sub_data",   32'(obs_data),      32'h7FFFE);
        checkOutput("sub_flag76", 32'(obs_flag[7:6]), 32'd3);

        hostWrite(3'd5, 19'h00123);
        applyStimulus({6'b000100, 3'd5, 3'd1, 3'd0, 3'd0}, 0, 1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
        checkOutput("div0_flag0", 32'(obs_flag[0]), 32'd1);
        checkOutput("div0_err",   32'(obs_err),     32'd1);
        readReg(3'd5);

        applyStimulus({6'b001010, 3'd2, 3'd1, 3'd1, 3'd0}, 0, 1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
        checkOutput("illegal_err", 32'(obs_err), 32'd1);
        readReg(3'd2);

        // Back-pressure, then back-to-back issue
        applyStimulus({6'b000001, 3'd6, 3'd1, 3'd2, 3'd0}, 5, 1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
        applyStimulus({6'b000111, 3'd4, 3'd1, 3'd2, 3'd0}, 0, 1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
        applyStimulus({6'b000011, 3'd5, 3'd2, 3'd2, 3'd0}, 0, 1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
        checkOutput("issue_interval_a", 32'(last_hs - prev_hs), 32'd40);
        applyStimulus({6'b001011, 3'd7, 3'd1, 3'd0, 3'd5}, 0, 1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
        checkOutput("issue_interval_b", 32'(last_hs - prev_hs), 32'd40);

        // Host write to rs1 on the ISSUE edge and to rd on the CAPTURE edge
        hostWrite(3'd1, 19'd5);
        hostWrite(3'd2, 19'd7);
        applyStimulus({6'b000001, 3'd6, 3'd1, 3'd2, 3'd0}, 0,
                      1'b1, 3'd1, 19'h11111, 1'b1, 3'd6, 19'h55555);
        checkOutput("collide_data", 32'(obs_data), 32'd12);
        readReg(3'd6);
        readReg(3'd1);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) hostWrite(3'($urandom_range(0, 7)), 19'($urandom));
            sel = $urandom_range(0, 9);
            if (sel < 8) begin
                sel = $urandom_range(0, 9);
                rop = (sel == 9) ? 6'd11 : 6'(sel + 1);
            end else begin
                sel = $urandom_range(0, 53);
                rop = (sel == 0) ? 6'd0 : (sel == 1) ? 6'd10 : 6'(sel + 10);
            end
            rins = {rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            applyStimulus(rins, $urandom_range(0, 2),
                          ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 19'($urandom),
                          ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 19'($urandom));
        end
        for (int i = 0; i < 8; i++) readReg(3'(i));

        // Reset while the instruction is in CAPTURE
        hostWrite(3'd1, 19'd3);
        hostWrite(3'd2, 19'd4);
        guard = 0;
        @(negedge clk);
        while (instr_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("midrst_pre_ready", 32'(instr_ready), 32'd1);
        instr       = {6'b000001, 3'd7, 3'd1, 3'd2, 3'd0};
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        checkOutput("midrst_issue_aluen", 32'(aluen), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(res_valid),   32'd0);
        checkOutput("midrst_aluen", 32'(aluen),       32'd0);
        checkOutput("midrst_ready", 32'(instr_ready), 32'd0);
        checkOutput("midrst_data",  32'(res_data),    32'd0);
        checkOutput("midrst_err",   32'(res_err),     32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_hold_valid", 32'(res_valid), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("midrst_rel_ready0", 32'(instr_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("midrst_rel_ready1", 32'(instr_ready), 32'd1);
        checkOutput("midrst_rel_valid",  32'(res_valid),   32'd0);
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;
        readReg(3'd7);
        readReg(3'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-003 SHALL have port instr_valid, input, 1 bit: instruction word on instr is valid.
REQ-004 SHALL have port instr_ready, output, 1 bit: block accepts instr this cycle.
REQ-005 SHALL have port instr, input, 18 bits: [17:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] imm.
REQ-006 SHALL have port rf_we, input, 1 bit: host register-file write strobe.
REQ-007 SHALL have port rf_waddr, input, 3 bits: host write address.
REQ-008 SHALL have port rf_wdata, input, 19 bits: host write data.
REQ-009 SHALL have ALU-side ports aluen (output, 1), opcode (output, 6), r2 (output, 19), r3 (output, 19), imm (output, 3): request to the ALU.
REQ-010 SHALL have ALU-side ports r1 (input, 19) and FLAG (input, 8): ALU result, valid one cycle after the aluen edge.
REQ-011 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_data (output, 19), res_flag (output, 8), res_err (output, 1): result channel.

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
REQ-013 SHALL assert instr_ready only in IDLE; handshake = instr_valid & instr_ready.
REQ-014 On handshake with a legal opcode (000001-001001, 001011), SHALL latch the fields and go to ISSUE.
REQ-015 On handshake with any other opcode, SHALL go directly to RESP with res_err=1, res_data=0, res_flag=0, and no ALU issue or writeback.
REQ-016 In ISSUE, SHALL drive aluen=1, opcode, r2=RF[rs1], r3=RF[rs2], imm for exactly one cycle.
REQ-017 Outside ISSUE, SHALL drive aluen=0 and opcode/r2/r3/imm=0.
REQ-018 In CAPTURE, SHALL sample r1/FLAG into res_data/res_flag at the closing edge; the ALU clears r1 one cycle later, so no other capture point is allowed.
REQ-019 At the CAPTURE edge, SHALL write RF[rd]=r1 unless FLAG[0]=1 (divide-by-zero), in which case the writeback is suppressed and res_err=1.
REQ-020 In RESP, SHALL hold res_valid=1 with stable res_data/res_flag/res_err until res_ready=1, then return to IDLE.
REQ-021 Latency SHALL be 3 cycles from handshake to the first res_valid; minimum issue interval SHALL be 4 cycles.
REQ-022 Host write (rf_we=1) SHALL update RF in any state; same-edge collision with writeback to the same address SHALL resolve with writeback winning.
REQ-023 Operand reads SHALL occur in ISSUE; a host write to rs1/rs2 on the ISSUE edge SHALL NOT affect the issued operands.
REQ-024 Register file SHALL be 8 x 19 bits; R0 is an ordinary register.

Reset
REQ-025 While reset=0, SHALL force state=IDLE, RF all 0, and all outputs 0, including instr_ready=0.
REQ-026 SHALL raise instr_ready=1 on the first clock edge after reset deasserts.
REQ-027 Reset mid-operation SHALL abandon the instruction with no writeback and no res_valid.

Configuration
REQ-028 With macro ALU_ISSUE_STICKY_FLAG_EN defined, SHALL add output sticky_flag (8 bits) that ORs in every captured FLAG, cleared only by reset.
REQ-029 Without ALU_ISSUE_STICKY_FLAG_EN, the port and its logic SHALL be absent.

Structure
REQ-030 SHALL place the opcode constants, the instruction field positions, the FSM state typedef and the 19-bit word width in shared package alu_pkg.
REQ-031 SHALL implement the register file as sub-module alu_regfile (2 async read ports, 1 write port with writeback priority).

Verification
REQ-032 Preload R1=5, R2=7; issue ADD (000001) rd=3, rs1=1, rs2=2 -> res_valid 3 cycles later, res_data=12, res_flag=0, RF[3]=12.
REQ-033 Issue SUB (000010) R1-R2 -> res_data=0x7FFFE, res_flag[7]=1, res_flag[6]=1.
REQ-034 Issue DIV (000100) with RF[rs2]=0 -> res_flag[0]=1, res_err=1, RF[rd] unchanged.
REQ-035 Issue opcode 001010 -> res_err=1 one cycle later, aluen never asserted, RF unchanged.
REQ-036 Hold res_ready=0 for 5 cycles in RESP -> res_* stable, instr_ready=0 throughout; a 4-cycle issue interval is met once res_ready=1 from the start.
REQ-037 Assert reset during CAPTURE -> no RF write, res_valid=0, all outputs 0, instr_ready=1 one edge after release.
